urv_dm_issue: RTL and testbench
===============================

// Module: urv_dm_issue
// PURPOSE
//  Data-memory issue stage between execute and writeback. Takes load/store requests and
//  drives the AHB-Lite master address phase (HADDR/HTRANS/HWRITE/HSIZE). Produces
//  lane-replicated store data (x_HWDATA) and the data-phase copies of fun/addr/load/store
//  that writeback consumes. At most one address phase plus one data phase in flight.
// PARAMETERS
//  none.
// PORTS
//  clk_i           in   1   clock
//  rst_i           in   1   reset, asynchronous, active-low
//  d_valid_i       in   1   request valid from execute
//  d_load_i        in   1   request is a load
//  d_store_i       in   1   request is a store
//  d_fun_i         in   3   LDST_* code (B/H/L/BU/HU)
//  d_addr_i        in   32  effective byte address
//  d_store_data_i  in   32  rs2 value, unaligned (bits [7:0]/[15:0] hold payload)
//  x_stall_i       in   1   global stall; no new request is accepted while high
//  x_stall_req_o   out  1   request present but address slot busy
//  HADDR           out  32  AHB address (registered)
//  HTRANS          out  2   IDLE=2'b00 / NONSEQ=2'b10 (registered)
//  HWRITE          out  1   AHB write (registered)
//  HSIZE           out  3   000 byte, 001 half, 010 word (registered)
//  x_HWDATA        out  32  replicated store data, held with address phase
//  HREADY          in   1   AHB ready
//  HRESP           in   1   AHB error response
//  x_valid_o       out  1   data phase in progress
//  x_load_o        out  1   data-phase copy of load
//  x_store_o       out  1   data-phase copy of store
//  x_fun_o         out  3   data-phase copy of fun
//  x_dm_addr_o     out  32  data-phase copy of address
//  bus_error_o     out  1   1-cycle pulse: data phase ended with HRESP=1
//  d_misalign_o    out  1   1-cycle pulse: misaligned request trapped (feature only)
// BEHAVIOUR
//  - Reset: HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=0, x_HWDATA=0, all x_* =0, pulses=0,
//    state IDLE. Mid-operation reset abandons both phases; no pulse after release.
//  - req = d_valid_i & (d_load_i|d_store_i). slot_free = (HTRANS==IDLE) | HREADY.
//  - accept = req & slot_free & !x_stall_i; x_stall_req_o = req & !slot_free.
//  - Accept at edge N: HTRANS=NONSEQ and HADDR/HWRITE/HSIZE/x_HWDATA valid from cycle
//    N+1. Held stable while HREADY=0. At an edge with no accept and HREADY=1, HTRANS->IDLE.
//  - Address phase completes at edge with HTRANS==NONSEQ & HREADY: x_valid_o=1 and
//    x_load/x_store/x_fun/x_dm_addr load from address-phase regs. Otherwise, x_valid_o
//    clears at an edge with HREADY=1. Back-to-back: new NONSEQ overlaps prior data phase.
//  - FSM {IDLE, ADDR, DATA, ADDR_DATA} = {addr phase pending, data phase pending}.
//    IDLE -accept-> ADDR; ADDR -HREADY-> DATA (or ADDR_DATA if accept same edge);
//    DATA -HREADY-> IDLE or ADDR on accept; ADDR_DATA -HREADY-> DATA / ADDR_DATA on accept.
//  - HSIZE = {1'b0, fun[1:0]}. x_HWDATA: byte -> {4{d[7:0]}}, half -> {2{d[15:0]}},
//    word -> d. Load requests set x_HWDATA=0.
//  - HRESP=1 with HREADY=1 in data phase -> bus_error_o pulse next cycle. A pending
//    address phase is not cancelled during error response.
//  - Simultaneous accept and data-phase completion is legal, no bubble.
// CONFIGURATION
//  KMKZ_DM_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 is
//    consumed without bus activity (HTRANS stays IDLE) and d_misalign_o pulses one
//    cycle after accept. Undefined: d_misalign_o tied 0; request issued with raw HADDR.
// STRUCTURE
//  kmkz_defs.v: LDST_* codes, HTRANS_IDLE/HTRANS_NONSEQ, HSIZE_B/H/W.
//  Sub-module urv_dm_lane_align (combinational): fun+data -> HSIZE, x_HWDATA, misalign flag.
// TESTING
//  1 SB addr 0x1003 data 0xAB, HREADY=1 -> next cycle HADDR=0x1003 HSIZE=000 NONSEQ
//    HWRITE=1 x_HWDATA=0xABABABAB; following cycle x_valid_o=1 x_store_o=1.
//  2 LW 0x2000 then LH 0x2006 back-to-back, HREADY=1 -> consecutive NONSEQ, no IDLE gap,
//    x_dm_addr_o 0x2000 then 0x2006.
//  3 SW 0x3000 with HREADY=0 for 3 cycles -> HADDR/x_HWDATA held, new LW raises
//    x_stall_req_o until HREADY=1.
//  4 Data phase HRESP=1: HREADY=0 then 1 -> single bus_error_o pulse, next request issued.
//  5 Assert rst_i=0 during ADDR_DATA -> HTRANS=IDLE, x_valid_o=0 immediately.
//  6 TRAP_EN: LW 0x4002 -> HTRANS stays IDLE, d_misalign_o=1 one cycle; without: NONSEQ.

Source files
------------

// File: rtl/urv_dm_issue_pkg.sv
// urv_dm_issue_pkg: shared codes for the data-memory issue stage.
// Holds LDST_* function codes, AHB HTRANS/HSIZE encodings and the issue FSM state type.
// Optional feature macro used by importers: KMKZ_DM_MISALIGN_TRAP_EN.
package urv_dm_issue_pkg;

  // Load/store function codes (funct3 of RISC-V loads/stores).
  localparam logic [2:0] LDST_B  = 3'b000;
  localparam logic [2:0] LDST_H  = 3'b001;
  localparam logic [2:0] LDST_L  = 3'b010;
  localparam logic [2:0] LDST_BU = 3'b100;
  localparam logic [2:0] LDST_HU = 3'b101;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_B = 3'b000;
  localparam logic [2:0] HSIZE_H = 3'b001;
  localparam logic [2:0] HSIZE_W = 3'b010;

  // Encoding is {address phase pending, data phase pending}.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_DATA      = 2'b01,
    ST_ADDR      = 2'b10,
    ST_ADDR_DATA = 2'b11
  } dm_state_e;

endpackage

// File: rtl/urv_dm_lane_align.sv
// urv_dm_lane_align: combinational lane steering for the data-memory issue stage.
// Ports: fun_i/addr_i/load_i/data_i -> size_o (HSIZE), wdata_o (replicated store data),
//        misalign_o (half on odd address or word not on a 4-byte boundary). No state.
module urv_dm_lane_align
  import urv_dm_issue_pkg::*;
(
  input  logic [1:0]  fun_i,
  input  logic [1:0]  addr_i,
  input  logic        load_i,
  input  logic [31:0] data_i,
  output logic [2:0]  size_o,
  output logic [31:0] wdata_o,
  output logic        misalign_o
);

  always_comb begin
    size_o     = {1'b0, fun_i};
    wdata_o    = '0;
    misalign_o = 1'b0;
    case (fun_i)
      2'b00: wdata_o = {4{data_i[7:0]}};
      2'b01: begin
        wdata_o    = {2{data_i[15:0]}};
        misalign_o = addr_i[0];
      end
      default: begin
        wdata_o    = data_i;
        misalign_o = (addr_i != 2'b00);
      end
    endcase
    // Loads never drive the write bus.
    if (load_i) wdata_o = '0;
  end

endmodule

// File: rtl/urv_dm_issue.sv
// urv_dm_issue: data-memory issue stage, drives the AHB-Lite address phase and tracks the data phase.
// Latency: request accepted at edge N is on HADDR/HTRANS from N+1; x_valid_o follows once HREADY completes it.
// Backpressure: x_stall_req_o while the address slot is busy (NONSEQ with HREADY=0); x_stall_i blocks acceptance.
// Ports: d_* request in, HADDR/HTRANS/HWRITE/HSIZE/x_HWDATA AHB address phase out, HREADY/HRESP in,
//        x_* data-phase copies, bus_error_o / d_misalign_o single-cycle pulses.
// Option: KMKZ_DM_MISALIGN_TRAP_EN traps misaligned half/word requests instead of issuing them.
module urv_dm_issue
  import urv_dm_issue_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        d_valid_i,
  input  logic        d_load_i,
  input  logic        d_store_i,
  input  logic [2:0]  d_fun_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_store_data_i,
  input  logic        x_stall_i,
  output logic        x_stall_req_o,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] x_HWDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  output logic        x_valid_o,
  output logic        x_load_o,
  output logic        x_store_o,
  output logic [2:0]  x_fun_o,
  output logic [31:0] x_dm_addr_o,
  output logic        bus_error_o,
  output logic        d_misalign_o
);

  dm_state_e   state_q, state_d;
  logic        addr_pend, data_pend;
  logic        req, slot_free, accept, trap, issue;
  logic [2:0]  lane_size;
  logic [31:0] lane_wdata;
  logic        lane_misalign;

  logic [31:0] haddr_q, hwdata_q, x_addr_q;
  logic [2:0]  hsize_q, a_fun_q, x_fun_q;
  logic        hwrite_q, a_load_q, x_load_q, x_store_q, bus_err_q;

  urv_dm_lane_align u_align (
    .fun_i      (d_fun_i[1:0]),
    .addr_i     (d_addr_i[1:0]),
    .load_i     (d_load_i),
    .data_i     (d_store_data_i),
    .size_o     (lane_size),
    .wdata_o    (lane_wdata),
    .misalign_o (lane_misalign)
  );

  assign addr_pend = (state_q == ST_ADDR) || (state_q == ST_ADDR_DATA);
  assign data_pend = (state_q == ST_DATA) || (state_q == ST_ADDR_DATA);

  assign req           = d_valid_i & (d_load_i | d_store_i);
  assign slot_free     = !addr_pend | HREADY;
  assign accept        = req & slot_free & !x_stall_i;
  assign x_stall_req_o = req & !slot_free;

`ifdef KMKZ_DM_MISALIGN_TRAP_EN
  logic misalign_q;
  assign trap = lane_misalign;

  // A trapped request is consumed here; it never reaches the bus.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) misalign_q <= 1'b0;
    else        misalign_q <= accept & trap;
  end
  assign d_misalign_o = misalign_q;
`else
  logic unused_misalign;
  assign unused_misalign = lane_misalign;
  assign trap            = 1'b0;
  assign d_misalign_o    = 1'b0;
`endif

  assign issue = accept & !trap;

  // issue can only coincide with a busy address slot when HREADY=1 (slot_free).
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (issue)  state_d = ST_ADDR;
      ST_ADDR:      if (HREADY) state_d = issue ? ST_ADDR_DATA : ST_DATA;
      ST_DATA: begin
        if (HREADY)     state_d = issue ? ST_ADDR : ST_IDLE;
        else if (issue) state_d = ST_ADDR_DATA;
      end
      ST_ADDR_DATA: if (HREADY) state_d = issue ? ST_ADDR_DATA : ST_DATA;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= ST_IDLE;
      haddr_q   <= '0;
      hwrite_q  <= 1'b0;
      hsize_q   <= '0;
      hwdata_q  <= '0;
      a_load_q  <= 1'b0;
      a_fun_q   <= '0;
      x_load_q  <= 1'b0;
      x_store_q <= 1'b0;
      x_fun_q   <= '0;
      x_addr_q  <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (issue) begin
        haddr_q  <= d_addr_i;
        hwrite_q <= d_store_i;
        hsize_q  <= lane_size;
        hwdata_q <= lane_wdata;
        a_load_q <= d_load_i;
        a_fun_q  <= d_fun_i;
      end
      // Address phase completes: its attributes move to the data-phase copies.
      if (addr_pend && HREADY) begin
        x_load_q  <= a_load_q;
        x_store_q <= hwrite_q;
        x_fun_q   <= a_fun_q;
        x_addr_q  <= haddr_q;
      end
      // Only the final (HREADY=1) cycle of the two-cycle error response counts.
      bus_err_q <= data_pend & HREADY & HRESP;
    end
  end

  assign HTRANS      = addr_pend ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HADDR       = haddr_q;
  assign HWRITE      = hwrite_q;
  assign HSIZE       = hsize_q;
  assign x_HWDATA    = hwdata_q;
  assign x_valid_o   = data_pend;
  assign x_load_o    = x_load_q;
  assign x_store_o   = x_store_q;
  assign x_fun_o     = x_fun_q;
  assign x_dm_addr_o = x_addr_q;
  assign bus_error_o = bus_err_q;

endmodule

// File: tb/tb_urv_dm_issue.sv
// tb_urv_dm_issue: scoreboard bench for urv_dm_issue.
// Expected address/data phases are queued when a request is accepted and compared when the
// bus shows the phase completing; directed checks cover timing, stalls, errors and reset.
module tb_urv_dm_issue;
  import urv_dm_issue_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        d_valid_i, d_load_i, d_store_i, x_stall_i;
  logic [2:0]  d_fun_i;
  logic [31:0] d_addr_i, d_store_data_i;
  logic        x_stall_req_o;
  logic [31:0] HADDR, x_HWDATA, x_dm_addr_o;
  logic [1:0]  HTRANS;
  logic        HWRITE, HREADY, HRESP;
  logic [2:0]  HSIZE, x_fun_o;
  logic        x_valid_o, x_load_o, x_store_o, bus_error_o, d_misalign_o;

  urv_dm_issue dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .d_valid_i(d_valid_i), .d_load_i(d_load_i), .d_store_i(d_store_i),
    .d_fun_i(d_fun_i), .d_addr_i(d_addr_i), .d_store_data_i(d_store_data_i),
    .x_stall_i(x_stall_i), .x_stall_req_o(x_stall_req_o),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .x_HWDATA(x_HWDATA), .HREADY(HREADY), .HRESP(HRESP),
    .x_valid_o(x_valid_o), .x_load_o(x_load_o), .x_store_o(x_store_o),
    .x_fun_o(x_fun_o), .x_dm_addr_o(x_dm_addr_o),
    .bus_error_o(bus_error_o), .d_misalign_o(d_misalign_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [2:0]  fun;
    logic        load;
  } exp_t;

  exp_t addr_q[$];
  exp_t data_q[$];
  exp_t mon_e;
  int   tests_run    = 0;
  int   tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [2:0] exp_size(input logic [2:0] fun);
    case (fun)
      LDST_B, LDST_BU: return 3'b000;
      LDST_H, LDST_HU: return 3'b001;
      default:         return 3'b010;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata(input logic ld, input logic [2:0] fun, input logic [31:0] d);
    if (ld) return 32'h0;
    case (fun)
      LDST_B:  return {d[7:0], d[7:0], d[7:0], d[7:0]};
      LDST_H:  return {d[15:0], d[15:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic exp_misalign(input logic [2:0] fun, input logic [31:0] a);
    if (fun == LDST_H || fun == LDST_HU) return a[0];
    if (fun == LDST_L) return a[1:0] != 2'b00;
    return 1'b0;
  endfunction

  task automatic push_exp(input logic ld, input logic st, input logic [2:0] fun,
                          input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.addr  = a;
    e.write = st;
    e.size  = exp_size(fun);
    e.wdata = exp_wdata(ld, fun, d);
    e.fun   = fun;
    e.load  = ld;
    addr_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic ld, input logic st, input logic [2:0] fun,
                       input logic [31:0] a, input logic [31:0] d);
    d_valid_i      = 1'b1;
    d_load_i       = ld;
    d_store_i      = st;
    d_fun_i        = fun;
    d_addr_i       = a;
    d_store_data_i = d;
  endtask

  task automatic idle_req();
    d_valid_i = 1'b0;
    d_load_i  = 1'b0;
    d_store_i = 1'b0;
  endtask

  // Present a request, wait (bounded) until it is accepted, return 1 ns after the accept edge.
  task automatic send(input logic ld, input logic st, input logic [2:0] fun,
                      input logic [31:0] a, input logic [31:0] d);
    int  n;
    bit  on_bus;
    drive(ld, st, fun, a, d);
    n = 0;
    @(negedge clk_i);
    while (x_stall_req_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 50) check("send_accept_timeout", 32'd1, 32'd0);
    @(posedge clk_i);
    #1;
    idle_req();
    on_bus = 1'b1;
`ifdef KMKZ_DM_MISALIGN_TRAP_EN
    on_bus = !exp_misalign(fun, a);
`endif
    if (on_bus) push_exp(ld, st, fun, a, d);
  endtask

  // Scoreboard monitor: sampled mid-cycle, HREADY is the value the next edge will see.
  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        if (x_valid_o && HREADY) begin
          if (data_q.size() == 0) check("sb_data_unexpected", 32'd1, 32'd0);
          else begin
            mon_e = data_q.pop_front();
            check("sb_x_dm_addr", x_dm_addr_o, mon_e.addr);
            check("sb_x_fun", {29'd0, x_fun_o}, {29'd0, mon_e.fun});
            check("sb_x_load", {31'd0, x_load_o}, {31'd0, mon_e.load});
            check("sb_x_store", {31'd0, x_store_o}, {31'd0, mon_e.write});
          end
        end
        if (HTRANS == HTRANS_NONSEQ && HREADY) begin
          if (addr_q.size() == 0) check("sb_addr_unexpected", 32'd1, 32'd0);
          else begin
            mon_e = addr_q.pop_front();
            check("sb_haddr", HADDR, mon_e.addr);
            check("sb_hwrite", {31'd0, HWRITE}, {31'd0, mon_e.write});
            check("sb_hsize", {29'd0, HSIZE}, {29'd0, mon_e.size});
            check("sb_hwdata", x_HWDATA, mon_e.wdata);
            data_q.push_back(mon_e);
          end
        end
      end
    end
  end

  initial begin
    rst_i = 1'b0;
    idle_req();
    d_fun_i = 3'b000; d_addr_i = '0; d_store_data_i = '0;
    x_stall_i = 1'b0; HREADY = 1'b1; HRESP = 1'b0;
    #12;
    check("rst_htrans", {30'd0, HTRANS}, 32'h0);
    check("rst_haddr", HADDR, 32'h0);
    check("rst_hwdata", x_HWDATA, 32'h0);
    check("rst_x_valid", {31'd0, x_valid_o}, 32'h0);
    check("rst_bus_error", {31'd0, bus_error_o}, 32'h0);
    step();
    rst_i = 1'b1;
    step();

    // 1: SB replicates the byte on all lanes
    send(1'b0, 1'b1, LDST_B, 32'h0000_1003, 32'h0000_00AB);
    check("t1_htrans", {30'd0, HTRANS}, 32'h2);
    check("t1_haddr", HADDR, 32'h0000_1003);
    check("t1_hsize", {29'd0, HSIZE}, 32'h0);
    check("t1_hwrite", {31'd0, HWRITE}, 32'h1);
    check("t1_hwdata", x_HWDATA, 32'hABAB_ABAB);
    check("t1_x_valid_early", {31'd0, x_valid_o}, 32'h0);
    step();
    check("t1_x_valid", {31'd0, x_valid_o}, 32'h1);
    check("t1_x_store", {31'd0, x_store_o}, 32'h1);
    check("t1_htrans_idle", {30'd0, HTRANS}, 32'h0);
    step();

    // 2: back-to-back LW / LH, no IDLE between
    send(1'b1, 1'b0, LDST_L, 32'h0000_2000, 32'h0);
    check("t2_htrans_a", {30'd0, HTRANS}, 32'h2);
    check("t2_hwdata_load", x_HWDATA, 32'h0);
    send(1'b1, 1'b0, LDST_H, 32'h0000_2006, 32'h0);
    check("t2_htrans_b", {30'd0, HTRANS}, 32'h2);
    check("t2_haddr_b", HADDR, 32'h0000_2006);
    check("t2_x_addr_a", x_dm_addr_o, 32'h0000_2000);
    step();
    check("t2_x_addr_b", x_dm_addr_o, 32'h0000_2006);
    check("t2_x_valid_b", {31'd0, x_valid_o}, 32'h1);
    step();
    check("t2_x_valid_end", {31'd0, x_valid_o}, 32'h0);

    // global stall blocks acceptance without raising stall request
    x_stall_i = 1'b1;
    drive(1'b1, 1'b0, LDST_L, 32'h0000_8000, 32'h0);
    step();
    step();
    check("stall_htrans", {30'd0, HTRANS}, 32'h0);
    check("stall_req_idle", {31'd0, x_stall_req_o}, 32'h0);
    x_stall_i = 1'b0;
    send(1'b1, 1'b0, LDST_L, 32'h0000_8000, 32'h0);
    check("stall_release", {30'd0, HTRANS}, 32'h2);
    step();
    step();

    // 3: SW with HREADY low for three edges, LW behind it must stall
    HREADY = 1'b0;
    send(1'b0, 1'b1, LDST_L, 32'h0000_3000, 32'h1234_5678);
    drive(1'b1, 1'b0, LDST_L, 32'h0000_3004, 32'h0);
    #1;
    check("t3_stall_req_0", {31'd0, x_stall_req_o}, 32'h1);
    for (int i = 0; i < 2; i++) begin
      step();
      check("t3_haddr_hold", HADDR, 32'h0000_3000);
      check("t3_hwdata_hold", x_HWDATA, 32'h1234_5678);
      check("t3_stall_req", {31'd0, x_stall_req_o}, 32'h1);
    end
    HREADY = 1'b1;
    #1;
    check("t3_stall_req_clear", {31'd0, x_stall_req_o}, 32'h0);
    push_exp(1'b1, 1'b0, LDST_L, 32'h0000_3004, 32'h0);
    @(posedge clk_i);
    #1;
    idle_req();
    check("t3_haddr_next", HADDR, 32'h0000_3004);
    check("t3_x_addr_sw", x_dm_addr_o, 32'h0000_3000);
    step();
    step();

    // 4: error response on a data phase, next request issued during it
    send(1'b1, 1'b0, LDST_L, 32'h0000_5000, 32'h0);
    step();
    HREADY = 1'b0;
    HRESP  = 1'b1;
    step();
    check("t4_no_err_yet", {31'd0, bus_error_o}, 32'h0);
    HREADY = 1'b1;
    send(1'b1, 1'b0, LDST_L, 32'h0000_5004, 32'h0);
    HRESP = 1'b0;
    check("t4_bus_error", {31'd0, bus_error_o}, 32'h1);
    check("t4_next_issue", HADDR, 32'h0000_5004);
    step();
    check("t4_bus_error_end", {31'd0, bus_error_o}, 32'h0);
    step();
    step();

    // 6: misaligned word
    send(1'b1, 1'b0, LDST_L, 32'h0000_4002, 32'h0);
`ifdef KMKZ_DM_MISALIGN_TRAP_EN
    check("t6_trap_htrans", {30'd0, HTRANS}, 32'h0);
    check("t6_trap_pulse", {31'd0, d_misalign_o}, 32'h1);
`else
    check("t6_raw_htrans", {30'd0, HTRANS}, 32'h2);
    check("t6_raw_haddr", HADDR, 32'h0000_4002);
    check("t6_no_pulse", {31'd0, d_misalign_o}, 32'h0);
`endif
    step();
    check("t6_pulse_end", {31'd0, d_misalign_o}, 32'h0);
    step();

    // SH replicates the halfword
    send(1'b0, 1'b1, LDST_H, 32'h0000_7002, 32'hDEAD_BEEF);
    check("sh_hwdata", x_HWDATA, 32'hBEEF_BEEF);
    check("sh_hsize", {29'd0, HSIZE}, 32'h1);
    step();
    step();

    // 5: reset in ADDR_DATA abandons both phases immediately
    send(1'b1, 1'b0, LDST_L, 32'h0000_6000, 32'h0);
    send(1'b1, 1'b0, LDST_L, 32'h0000_6004, 32'h0);
    rst_i = 1'b0;
    #1;
    check("t5_htrans", {30'd0, HTRANS}, 32'h0);
    check("t5_x_valid", {31'd0, x_valid_o}, 32'h0);
    check("t5_haddr", HADDR, 32'h0);
    addr_q.delete();
    data_q.delete();
    step();
    rst_i = 1'b1;
    step();
    step();
    check("t5_after_x_valid", {31'd0, x_valid_o}, 32'h0);
    check("t5_after_htrans", {30'd0, HTRANS}, 32'h0);
    check("t5_after_err", {31'd0, bus_error_o}, 32'h0);

    check("sb_addr_drained", addr_q.size(), 32'd0);
    check("sb_data_drained", data_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
